mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 170 +++++++++++++++++
 tb/tb_mul_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb.sv
// mul_arb: two-requester round-robin front end for a shared multiplier.
//
// Ports
//   mul_clk, reset                clock (rising edge), synchronous active-high reset
//   reqN_valid/ready/x/y/signed   request channel N (accept on valid && ready)
//   rspN_valid/ready/result/err   response channel N (taken on valid && ready)
//   m_mul, m_x, m_y, m_signed     start pulse and operands to the multiplier
//   m_complete, m_result          completion strobe and product from the multiplier
//
// Parameter
//   MAX_WAIT                      WAIT cycles allowed for m_complete before abort
//
// Build option
//   MUL_ARB_ZERO_BYPASS_EN        when defined, requests with a zero operand
//                                 skip the multiplier and answer 0 directly
//
// state | meaning
// IDLE  | arbitrate between requesters, ready is combinational
// ISSUE | one-cycle m_mul pulse with latched operands
// WAIT  | wait for m_complete, abort after MAX_WAIT cycles
// RESP  | hold owner's response until rsp_ready

module mul_arb #(
  parameter int MAX_WAIT = 80
) (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic        req1_signed,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_result,
  output logic        rsp1_err,
  output logic        m_mul,
  output logic [31:0] m_x,
  output logic [31:0] m_y,
  output logic        m_signed,
  input  logic        m_complete,
  input  logic [63:0] m_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The WAIT cycle whose count is MAX_WAIT-1 is the last one allowed.
  localparam logic [6:0] WAIT_LAST = 7'(MAX_WAIT - 1);

  state_t      state;
  logic        ptr;
  logic        owner;
  logic [6:0]  wait_cnt;

  logic        grant0;
  logic        grant1;
  logic [31:0] sel_x;
  logic [31:0] sel_y;
  logic        sel_signed;
  logic        zero_op;
  logic        rsp_done;

  always_comb begin
    // reset gates ready so no handshake can be seen while reset is held
    grant0     = !reset && (state == IDLE) && req0_valid && (!req1_valid || !ptr);
    grant1     = !reset && (state == IDLE) && req1_valid && (!req0_valid ||  ptr);
    sel_x      = grant1 ? req1_x      : req0_x;
    sel_y      = grant1 ? req1_y      : req0_y;
    sel_signed = grant1 ? req1_signed : req0_signed;
`ifdef MUL_ARB_ZERO_BYPASS_EN
    zero_op    = (sel_x == 32'd0) || (sel_y == 32'd0);
`else
    zero_op    = 1'b0;
`endif
    rsp_done   = owner ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      wait_cnt    <= 7'd0;
      m_mul       <= 1'b0;
      m_x         <= 32'd0;
      m_y         <= 32'd0;
      m_signed    <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= 64'd0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= 64'd0;
      rsp1_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner <= grant1;
            ptr   <= !grant1;
            if (zero_op) begin
              state       <= RESP;
              rsp0_valid  <= !grant1;
              rsp1_valid  <= grant1;
              rsp0_result <= 64'd0;
              rsp1_result <= 64'd0;
              rsp0_err    <= 1'b0;
              rsp1_err    <= 1'b0;
            end else begin
              state    <= ISSUE;
              m_mul    <= 1'b1;
              m_x      <= sel_x;
              m_y      <= sel_y;
              m_signed <= sel_signed;
            end
          end
        end
        ISSUE: begin
          m_mul    <= 1'b0;
          wait_cnt <= 7'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // completion on the final allowed cycle still wins over the abort
          if (m_complete || (wait_cnt == WAIT_LAST)) begin
            state    <= RESP;
            m_x      <= 32'd0;
            m_y      <= 32'd0;
            m_signed <= 1'b0;
            if (!owner) begin
              rsp0_valid  <= 1'b1;
              rsp0_result <= m_complete ? m_result : 64'd0;
              rsp0_err    <= !m_complete;
            end else begin
              rsp1_valid  <= 1'b1;
              rsp1_result <= m_complete ? m_result : 64'd0;
              rsp1_err    <= !m_complete;
            end
          end else begin
            wait_cnt <= wait_cnt + 7'd1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            state       <= IDLE;
            rsp0_valid  <= 1'b0;
            rsp0_result <= 64'd0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= 64'd0;
            rsp1_err    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: scoreboard bench for mul_arb with a behavioural multiplier.
// Requests are queued per side, expected responses are pushed on accept and
// popped when the response handshake is seen.

module tb_mul_arb;

  localparam int MAX_WAIT = 80;

  logic        mul_clk;
  logic        reset;
  logic        req0_valid, req0_ready, req0_signed;
  logic [31:0] req0_x, req0_y;
  logic        req1_valid, req1_ready, req1_signed;
  logic [31:0] req1_x, req1_y;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic [63:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [63:0] rsp1_result;
  logic        m_mul, m_signed, m_complete;
  logic [31:0] m_x, m_y;
  logic [63:0] m_result;

  mul_arb #(.MAX_WAIT(MAX_WAIT)) dut (
    .mul_clk(mul_clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_signed(req1_signed),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_err(rsp1_err),
    .m_mul(m_mul), .m_x(m_x), .m_y(m_y), .m_signed(m_signed),
    .m_complete(m_complete), .m_result(m_result)
  );

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {logic [31:0] x; logic [31:0] y; logic s;} req_t;
  typedef struct {bit owner; logic [63:0] result; bit err;} rsp_t;

  req_t req_q0[$];
  req_t req_q1[$];
  rsp_t sb[$];
  bit   acc_log[$];
  int   first_iter;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] a, b;
    a = s ? {{32{x[31]}}, x} : {32'd0, x};
    b = s ? {{32{y[31]}}, y} : {32'd0, y};
    return a * b;
  endfunction

  // ---------------- multiplier model ----------------
  int          mul_delay = 1;
  int          mcnt;
  bit          mpend = 0;
  logic [31:0] mx, my, exp_x, exp_y;
  logic        ms, exp_s;
  int          mul_pulses = 0;
  logic        model_cmp = 1'b0;
  logic [63:0] model_res = 64'd0;
  logic        spur = 1'b0;

  assign m_complete = model_cmp | spur;
  assign m_result   = spur ? 64'hDEAD_BEEF_0BAD_F00D : model_res;

  always @(negedge mul_clk) begin
    model_cmp = 1'b0;
    if (mpend) begin
      check_val("wait_ops_hold", {m_x, m_y}, {mx, my});
      mcnt--;
      if (mcnt == 0) begin
        model_cmp = 1'b1;
        model_res = prod(mx, my, ms);
        mpend     = 0;
      end
    end
    if (m_mul === 1'b1) begin
      mul_pulses++;
      mx = m_x; my = m_y; ms = m_signed;
      check_val("issue_ops", {m_x, m_y}, {exp_x, exp_y});
      check_val("issue_signed", m_signed, exp_s);
      mpend = (mul_delay > 0);
      mcnt  = mul_delay;
    end
  end

  // ---------------- response monitor ----------------
  bit          prev_hold[2];
  logic [63:0] prev_res[2];
  logic        prev_err[2];
  int          rsp1_cycles = 0;

  task automatic pop_compare(input bit side);
    rsp_t t;
    if (sb.size() == 0) begin
      check_val("sb_unexpected_rsp", 1, 0);
    end else begin
      t = sb.pop_front();
      check_val("rsp_owner", side, t.owner);
      check_val("rsp_result", side ? rsp1_result : rsp0_result, t.result);
      check_val("rsp_err", side ? rsp1_err : rsp0_err, t.err);
    end
  endtask

  task automatic mon_side(input bit side, input logic v, input logic rdy,
                          input logic [63:0] res, input logic e, input logic ov);
    if (prev_hold[side]) begin
      check_val("rsp_valid_hold", v, 1);
      check_val("rsp_result_hold", res, prev_res[side]);
      check_val("rsp_err_hold", e, prev_err[side]);
    end
    if (v) begin
      check_val("rsp_onehot", ov, 0);
      if (rdy) pop_compare(side);
    end
    prev_hold[side] = v && !rdy;
    prev_res[side]  = res;
    prev_err[side]  = e;
  endtask

  always @(negedge mul_clk) begin
    #2;
    if (reset === 1'b0) begin
      if (rsp1_valid) rsp1_cycles++;
      mon_side(0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_err, rsp1_valid);
      mon_side(1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_err, rsp0_valid);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic add_req(input bit side, input logic [31:0] x, input logic [31:0] y, input logic s);
    req_t r;
    r = '{x: x, y: y, s: s};
    if (side) req_q1.push_back(r); else req_q0.push_back(r);
  endtask

  task automatic log_accept(input bit side, input req_t r, input int iter);
    rsp_t t;
    bit   bp;
    bp = 0;
`ifdef MUL_ARB_ZERO_BYPASS_EN
    bp = (r.x == 0) || (r.y == 0);
`endif
    acc_log.push_back(side);
    exp_x = r.x; exp_y = r.y; exp_s = r.s;
    t.owner  = side;
    t.err    = !bp && (mul_delay <= 0);
    t.result = t.err ? 64'd0 : prod(r.x, r.y, r.s);
    sb.push_back(t);
    if (first_iter == 0) first_iter = iter;
  endtask

  task automatic run_traffic();
    int   iter;
    req_t r;
    iter = 0;
    first_iter = 0;
    acc_log.delete();
    while ((req_q0.size() > 0 || req_q1.size() > 0) && iter < 600) begin
      @(negedge mul_clk);
      iter++;
      req0_valid = (req_q0.size() > 0);
      if (req0_valid) {req0_x, req0_y, req0_signed} = req_q0[0];
      req1_valid = (req_q1.size() > 0);
      if (req1_valid) {req1_x, req1_y, req1_signed} = req_q1[0];
      #2;
      if (req0_ready && req1_ready) check_val("grant_onehot", 1, 0);
      if (req0_valid && req0_ready) begin r = req_q0.pop_front(); log_accept(0, r, iter); end
      if (req1_valid && req1_ready) begin r = req_q1.pop_front(); log_accept(1, r, iter); end
    end
    @(negedge mul_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (iter >= 600) check_val("traffic_timeout", 1, 0);
  endtask

  // Called at the negedge after the final accept: returns the cycle offset
  // from accept at which rsp_valid of the given side is first seen.
  task automatic meas_latency(input bit side, output int n);
    n = 1;
    #2;
    while (!(side ? rsp1_valid : rsp0_valid) && n < 300) begin
      @(negedge mul_clk);
      #2;
      n++;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (sb.size() > 0 && c < 400) begin
      @(negedge mul_clk);
      #2;
      c++;
    end
    if (c >= 400) check_val("drain_timeout", sb.size(), 0);
    @(negedge mul_clk);
  endtask

  task automatic reset_dut();
    @(negedge mul_clk);
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge mul_clk);
    #2;
    check_val("rst_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                           rsp0_err, rsp1_err, m_mul, m_signed}, 0);
    check_val("rst_rsp0_result", rsp0_result, 0);
    check_val("rst_rsp1_result", rsp1_result, 0);
    check_val("rst_m_ops", {m_x, m_y}, 0);
    @(negedge mul_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    sb.delete();
  endtask

  int n;
  int pulses0;
  int rsp1_0;

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_x = 0; req0_y = 0; req0_signed = 0;
    req1_valid = 0; req1_x = 0; req1_y = 0; req1_signed = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    reset_dut();

    // basic unsigned product, accepted in the first cycle out of reset
    mul_delay = 33; pulses0 = mul_pulses; rsp1_0 = rsp1_cycles;
    add_req(0, 32'd3, 32'd5, 1'b0);
    run_traffic();
    check_val("accept_after_reset", first_iter, 1);
    meas_latency(0, n);
    check_val("latency_k33", n, 35);
    wait_idle();
    check_val("mul_pulses_basic", mul_pulses - pulses0, 1);
    check_val("rsp1_never", rsp1_cycles - rsp1_0, 0);

    // round robin: req0 keeps a second request pending behind req1
    reset_dut();
    mul_delay = 2;
    add_req(0, 32'd7, 32'd9, 1'b0);
    add_req(0, 32'd11, 32'd13, 1'b0);
    add_req(1, 32'd100, 32'd200, 1'b0);
    run_traffic();
    wait_idle();
    check_val("rr_count", acc_log.size(), 3);
    check_val("rr_order", {acc_log[0], acc_log[1], acc_log[2]}, 3'b010);
    add_req(0, 32'd1, 32'd1, 1'b0);
    add_req(1, 32'd2, 32'd2, 1'b0);
    run_traffic();
    wait_idle();
    check_val("rr_pair2", {acc_log[0], acc_log[1]}, 2'b10);

    // signed/unsigned operand handling
    mul_delay = 4;
    add_req(1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    add_req(0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    add_req(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_traffic();
    wait_idle();

    // timeout: multiplier never completes
    mul_delay = 0;
    add_req(0, 32'd6, 32'd7, 1'b0);
    run_traffic();
    meas_latency(0, n);
    check_val("latency_timeout", n, 2 + MAX_WAIT);
    wait_idle();

    // completion on the last allowed WAIT cycle still returns a result
    mul_delay = MAX_WAIT;
    add_req(1, 32'd9, 32'd9, 1'b0);
    run_traffic();
    meas_latency(1, n);
    check_val("latency_k_max", n, 2 + MAX_WAIT);
    wait_idle();

    // response back-pressure, stray m_complete in RESP, no accept meanwhile
    mul_delay = 3;
    rsp0_ready = 0;
    add_req(0, 32'd12, 32'd12, 1'b0);
    run_traffic();
    meas_latency(0, n);
    check_val("latency_k3", n, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge mul_clk);
      spur = 1'b1;
      req1_valid = 1'b1;
      #2;
      check_val("hold_no_accept", {req0_ready, req1_ready}, 0);
    end
    @(negedge mul_clk);
    spur = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1;
    wait_idle();

    // reset while waiting on the multiplier
    mul_delay = 0;
    add_req(0, 32'd5, 32'd5, 1'b0);
    run_traffic();
    repeat (5) @(negedge mul_clk);
    reset_dut();
    check_val("post_rst_sb", sb.size(), 0);

    // zero operand
    mul_delay = 2; pulses0 = mul_pulses;
    add_req(0, 32'd0, 32'd7, 1'b0);
    run_traffic();
    meas_latency(0, n);
    wait_idle();
`ifdef MUL_ARB_ZERO_BYPASS_EN
    check_val("bypass_latency", n <= 2, 1);
    check_val("bypass_no_mul", mul_pulses - pulses0, 0);
`else
    check_val("zero_latency", n, 4);
    check_val("zero_mul_pulse", mul_pulses - pulses0, 1);
`endif
    check_val("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
